instr_fetch_unit: RTL

//   IF-stage controller: owns the fetch PC, the instruction-memory request handshake and the
//   IF/ID pipeline register. It consumes the hazard unit's PCWrite/Stall and ID-stage branch flush.
//   It holds, refills or bubbles IF/ID and issues fetches to a variable-latency instruction memory.

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF-stage controller: fetch PC, imem handshake and IF/ID register
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        loaded;

  logic        consume;
  logic        ack_taken;
  logic [31:0] target;

  assign consume   = pc_write_i & ~stall_i;
  assign target    = branch_target_i & ~32'h3;
  // DISCARD keeps presenting the stale address so the memory sees a stable request until ack
  assign imem_req_o  = ~rst_i & (state_q != HOLD);
  assign imem_addr_o = (state_q == DISCARD) ? req_addr_q : fpc_q;
  assign ack_taken   = imem_ack_i & imem_req_o;

  assign if_id_pc_o    = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_valid_o = valid_q;

  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    loaded       = 1'b0;

    case (state_q)
      FETCH: begin
        if (flush_i) begin
          fpc_d = target;
          if (!ack_taken) begin
            state_d    = DISCARD;
            req_addr_d = fpc_q;
          end
        end else if (ack_taken) begin
          if (consume) begin
            pc_d    = fpc_q;
            instr_d = imem_rdata_i;
            valid_d = 1'b1;
            loaded  = 1'b1;
            fpc_d   = fpc_q + 32'd4;
          end else begin
            hold_instr_d = imem_rdata_i;
            hold_pc_d    = fpc_q;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          fpc_d   = target;
          state_d = FETCH;
        end else if (consume) begin
          pc_d    = hold_pc_q;
          instr_d = hold_instr_q;
          valid_d = 1'b1;
          loaded  = 1'b1;
          fpc_d   = fpc_q + 32'd4;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (flush_i) fpc_d = target;
        // the stale request is complete once acked, even if another flush arrives with it
        if (ack_taken) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (flush_i || (!stall_i && consume && !loaded)) begin
      pc_d    = 32'd0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      fpc_q        <= RESET_PC;
      req_addr_q   <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
      pc_q         <= 32'd0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

endmodule
